// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register and its skid stages.
package pipe_pkg;

    // Default data width of the pipeline register.
    localparam int unsigned DEFAULT_WIDTH = 32;

    // Width of an occupancy counter able to hold 0 .. 2*stages beats.
    function automatic int unsigned PIPE_COUNT_W(input int unsigned stages);
        return $clog2(2 * stages + 1);
    endfunction

    // Valid bits of one 2-entry skid stage: main and skid register.
    typedef struct packed {
        logic m_v;
        logic s_v;
    } stage_vld_t;

endpackage

// File: rtl/pipe_reg_elastic_if.sv
// Valid/ready handshake bundle for pipe_reg_elastic: input side (d) and output side (q).
interface pipe_reg_elastic_if
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;

    // Producer/consumer side, e.g. surrounding pipeline logic or a bench.
    modport master (
        output d, d_valid, q_ready,
        input  d_ready, q, q_valid
    );

    // The pipeline register itself.
    modport slave (
        input  d, d_valid, q_ready,
        output d_ready, q, q_valid
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// One 2-entry skid stage: main + skid register, upstream ready is registered (!s_v).
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    stage_vld_t       vld_q, vld_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             take;
    logic             in_acc;

    assign up_ready = !vld_q.s_v;
    assign dn_valid = vld_q.m_v;
    assign dn_data  = m_data_q;

    // Next-state of main/skid registers from the take/in handshake events.
    always_comb begin
        take     = vld_q.m_v && dn_ready;
        in_acc   = up_valid && !vld_q.s_v;
        vld_d    = vld_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (take && vld_q.s_v) begin
            // Skid refills main; skid cannot be loaded this cycle (ready was low).
            m_data_d  = s_data_q;
            vld_d.s_v = 1'b0;
        end else if ((take || !vld_q.m_v) && in_acc) begin
            m_data_d  = up_data;
            vld_d.m_v = 1'b1;
        end else if (take) begin
            vld_d.m_v = 1'b0;
        end
        // Main is stuck but upstream already saw ready: park the beat in skid.
        if (vld_q.m_v && !take && in_acc) begin
            s_data_d  = up_data;
            vld_d.s_v = 1'b1;
        end
    end

    // State register: reset clears everything, flush clears only valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            m_data_q <= '0;
            s_data_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            vld_q    <= vld_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

endmodule

// File: rtl/pipe_reg_elastic.sv
// STAGES-deep elastic pipeline register with valid/ready, flush and occupancy count.
// Optional even-parity protection of stored beats: define PIPE_REG_PARITY_EN.
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    pipe_reg_elastic_if.slave                bus,
    output logic [PIPE_COUNT_W(STAGES)-1:0]  count,
    output logic                             parity_err
);

`ifdef PIPE_REG_PARITY_EN
    localparam int unsigned PW = 1;
`else
    localparam int unsigned PW = 0;
`endif
    localparam int unsigned DW = WIDTH + PW;
    localparam int unsigned CW = PIPE_COUNT_W(STAGES);

    // Element k is the upstream side of stage k; element STAGES is the pipeline output.
    logic          ch_valid [STAGES+1];
    logic          ch_ready [STAGES+1];
    logic [DW-1:0] ch_data  [STAGES+1];

    logic          acc;
    logic          emit;
    logic [CW-1:0] count_q, count_d;

    // A beat offered during flush must not enter the pipeline.
    assign ch_valid[0] = bus.d_valid && !flush;
`ifdef PIPE_REG_PARITY_EN
    assign ch_data[0]  = {^bus.d, bus.d};
`else
    assign ch_data[0]  = bus.d;
`endif
    assign ch_ready[STAGES] = bus.q_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_skid_stage #(
            .WIDTH (DW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (ch_valid[k]),
            .up_data  (ch_data[k]),
            .up_ready (ch_ready[k]),
            .dn_valid (ch_valid[k+1]),
            .dn_data  (ch_data[k+1]),
            .dn_ready (ch_ready[k+1])
        );
    end

    assign bus.d_ready = ch_ready[0] && !flush;
    assign bus.q_valid = ch_valid[STAGES];
    assign bus.q       = ch_data[STAGES][WIDTH-1:0];

`ifdef PIPE_REG_PARITY_EN
    assign parity_err = ch_valid[STAGES] && ((^ch_data[STAGES][WIDTH-1:0]) != ch_data[STAGES][WIDTH]);
`else
    assign parity_err = 1'b0;
`endif

    assign acc   = bus.d_valid && bus.d_ready;
    assign emit  = bus.q_valid && bus.q_ready;
    assign count = count_q;

    // Occupancy: +1 on accept, -1 on emit, unchanged when both happen.
    always_comb begin
        count_d = count_q;
        if (acc && !emit) begin
            count_d = count_q + 1'b1;
        end else if (!acc && emit) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register; reset and flush both empty the pipeline.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed + randomised-stall bench for pipe_reg_elastic (WIDTH=32, STAGES=2).
// Parity checks are extended when PIPE_REG_PARITY_EN is defined.
module tb_pipe_reg_elastic;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count;
    logic       parity_err;

    int n_vec = 0;
    int n_err = 0;

    pipe_reg_elastic_if #(.WIDTH(32)) bus ();

    pipe_reg_elastic #(
        .WIDTH  (32),
        .STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .count      (count),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic        flush;
        logic        dv;
        logic [31:0] d;
        logic        qr;
        logic        e_dr;
        logic        e_qv;
        logic        chk_q;
        logic [31:0] e_q;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic f, input logic dv,
                                input logic [31:0] d, input logic qr, input logic e_dr,
                                input logic e_qv, input logic chk_q, input logic [31:0] e_q,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.rst = r; v.flush = f; v.dv = dv; v.d = d; v.qr = qr;
        v.e_dr = e_dr; v.e_qv = e_qv; v.chk_q = chk_q; v.e_q = e_q; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic dv, input logic [31:0] d,
                         input logic qr);
        @(negedge clk);
        rst = r; flush = f; bus.d_valid = dv; bus.d = d; bus.q_ready = qr;
        #1;
    endtask

    logic [31:0] model[$];
    logic        hold_dv;
    logic [31:0] hold_d;
    logic        acc, emit;
    logic [31:0] q_act;
`ifdef PIPE_REG_PARITY_EN
    logic [32:0] tmp;
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; bus.d_valid = 1'b0; bus.d = '0; bus.q_ready = 1'b0;
        repeat (2) @(posedge clk);

        // r: rst flush dv d qr | d_ready q_valid chk_q q count
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 0, 1, 32'h0,        0));
        tbl.push_back(mk(0, 0, 1, 32'hDEADBEEF, 1, 1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 1, 32'hDEADBEEF, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0));
        // backpressure until full
        tbl.push_back(mk(0, 0, 1, 32'd1,        0, 1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 1, 32'd2,        0, 1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 0, 1, 32'd3,        0, 1, 1, 1, 32'd1,        2));
        tbl.push_back(mk(0, 0, 1, 32'd4,        0, 1, 1, 1, 32'd1,        3));
        tbl.push_back(mk(0, 0, 1, 32'd5,        0, 0, 1, 1, 32'd1,        4));
        tbl.push_back(mk(0, 0, 1, 32'd5,        1, 0, 1, 1, 32'd1,        4));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 1, 1, 32'd2,        3));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 1, 32'd3,        2));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 1, 32'd4,        1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0));
        // fill to 3, flush with a beat offered, q keeps old data
        tbl.push_back(mk(0, 0, 1, 32'h11,       0, 1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 1, 32'h22,       0, 1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 0, 1, 32'h33,       0, 1, 1, 1, 32'h11,       2));
        tbl.push_back(mk(0, 1, 1, 32'h44,       0, 0, 1, 1, 32'h11,       3));
        tbl.push_back(mk(0, 0, 1, 32'h55,       1, 1, 0, 1, 32'h11,       0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 1, 32'h55,       1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0));
        // reset mid-traffic (with flush) also clears data
        tbl.push_back(mk(0, 0, 1, 32'h66,       0, 1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0, 1, 1, 32'h66,       1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 0, 1, 32'h0,        0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].dv, tbl[i].d, tbl[i].qr);
            q_act = tbl[i].chk_q ? bus.q : 32'h0;
            chk($sformatf("vec%0d {dr,qv,q,cnt,perr}", i),
                {26'h0, bus.d_ready, bus.q_valid, q_act, count, parity_err},
                {26'h0, tbl[i].e_dr, tbl[i].e_qv, (tbl[i].chk_q ? tbl[i].e_q : 32'h0),
                 tbl[i].e_cnt, 1'b0});
        end

        // Streaming 0..99 with q_ready=1: output i-2 in cycle i, no gaps.
        for (int i = 0; i < 102; i++) begin
            drive(0, 0, (i < 100), i, 1);
            if (i < 100) chk($sformatf("stream%0d d_ready", i), bus.d_ready, 1);
            chk($sformatf("stream%0d q_valid", i), bus.q_valid, (i >= 2));
            if (i >= 2) chk($sformatf("stream%0d q", i), bus.q, i - 2);
        end

        // Random stalls against a queue scoreboard; d held while not accepted.
        hold_dv = 1'b0;
        hold_d  = '0;
        for (int i = 0; i < 10000; i++) begin
            if (hold_dv) drive(0, 0, 1, hold_d, $urandom_range(0, 1));
            else         drive(0, 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
            chk($sformatf("rand%0d count", i), count, model.size());
            chk($sformatf("rand%0d parity_err", i), parity_err, 0);
            acc  = bus.d_valid && bus.d_ready;
            emit = bus.q_valid && bus.q_ready;
            if (emit) begin
                if (model.size() == 0) chk($sformatf("rand%0d emit_on_empty", i), 1, 0);
                else chk($sformatf("rand%0d q", i), bus.q, model.pop_front());
            end
            if (acc) model.push_back(bus.d);
            hold_dv = bus.d_valid && !acc;
            hold_d  = bus.d;
        end
        for (int i = 0; i < 20 && model.size() != 0; i++) begin
            drive(0, 0, 0, 0, 1);
            if (bus.q_valid) chk($sformatf("drain%0d q", i), bus.q, model.pop_front());
        end
        chk("drain empty", model.size(), 0);
        drive(0, 0, 0, 0, 1);
        chk("drain count", count, 0);

`ifdef PIPE_REG_PARITY_EN
        // Corrupt the beat sitting in the output stage main register.
        drive(0, 0, 1, 32'hA5, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        tmp = dut.g_stage[1].u_stage.m_data_q;
        force dut.g_stage[1].u_stage.m_data_q = tmp ^ 33'h1;
        #1;
        chk("parity corrupt q_valid", bus.q_valid, 1);
        chk("parity corrupt err", parity_err, 1);
        release dut.g_stage[1].u_stage.m_data_q;
        drive(0, 0, 1, 32'h3C, 1);
        chk("parity still corrupt err", parity_err, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("parity clean q", bus.q, 32'h3C);
        chk("parity clean err", parity_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor to the team's plain D flip-flop / 32-bit register: a STAGES-deep elastic pipeline register of width WIDTH with valid/ready handshake, synchronous flush and an occupancy count.
- Used between ALU and processor pipeline stages where downstream can stall, replacing bare dff_32 chains that drop or duplicate data under backpressure.

Parameters:
- WIDTH, 32, data width in bits (>=1)
- STAGES, 2, number of register stages (>=1); total capacity 2*STAGES beats

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline clear
- d  input  WIDTH  input data
- d_valid  input  1  input beat valid
- d_ready  output  1  pipeline can accept a beat
- q  output  WIDTH  output data, head of pipeline
- q_valid  output  1  q holds a valid beat
- q_ready  input  1  downstream accepts q this cycle
- count  output  $clog2(2*STAGES+1)  beats currently held
- parity_err  output  1  see Optional Feature

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset: all valid bits 0, all data registers 0. After reset: q=0, q_valid=0, count=0, parity_err=0, d_ready=1 (when flush=0).
- Handshake: accept when d_valid && d_ready; emit when q_valid && q_ready. d must hold stable while d_valid && !d_ready. q and q_valid are stable until emitted. No beat is lost, duplicated or reordered.
- Each stage is a 2-entry skid buffer with a main register (m_v, m_d) and a skid register (s_v, s_d).
  - upstream ready = !s_v (registered; no combinational ready path through stages)
  - downstream valid = m_v
- Stage update per edge, with "take" = m_v && downstream ready, "in" = upstream valid && !s_v:
  - take && s_v: main<=skid, s_v<=0
  - (take || !m_v) && !s_v && in: main<=input, m_v<=1
  - take && !in && !s_v: m_v<=0
  - m_v && !take && in: skid<=input, s_v<=1
- Stage chain: stage k downstream feeds stage k+1 upstream. Stage 0 connects to d. Stage STAGES-1 drives q.
- Latency: beat accepted at edge N into an empty pipeline gives q_valid=1 with that data after edge N+STAGES-1, i.e. STAGES cycles from d to q.
- Throughput: 1 beat/cycle sustained while q_ready=1.
- d_ready = !s_v of stage 0 && !flush. d_ready is the only combinational path (from flush).
- Full: 2*STAGES beats held; d_ready=0; count=2*STAGES.
- Empty: q_valid=0; q holds last value (don't-care); count=0.
- count: +1 on accept, -1 on emit, unchanged when both occur in the same cycle. Never exceeds 2*STAGES and never underflows.
- flush (rst=0): at the edge, all m_v/s_v<=0 and count<=0; data registers unchanged. A beat presented in the flush cycle is not accepted (d_ready=0). A q emitted in the flush cycle counts as consumed by downstream.
- rst mid-traffic: identical to flush, plus data cleared. rst has priority over flush.

Optional Feature:
- Macro: PIPE_REG_PARITY_EN.
- Enabled:
  - each main/skid register stores one extra even-parity bit computed from d at accept
  - parity_err = q_valid && (^q != stored parity), combinational
  - parity bits reset to 0
- Disabled:
  - no parity storage
  - parity_err tied to 0; port list unchanged

Decomposition:
- Shared package pipe_pkg:
  - PIPE_COUNT_W(stages) width function/constant
  - default WIDTH=32 constant
  - typedef for stage valid/data bundle
- Sub-module pipe_skid_stage (one 2-entry skid stage, WIDTH param), instantiated STAGES times by a generate loop in pipe_reg_elastic. The parity bit is appended to its data width when PIPE_REG_PARITY_EN is defined.

Test Plan:
- Reset/latency: rst=1 for 2 cycles, then WIDTH=32, STAGES=2, q_ready=1, one beat d=0xDEADBEEF → q_valid=1 with q=0xDEADBEEF exactly 2 cycles after accept; count goes 0→1→0.
- Streaming: 100 consecutive beats 0..99, q_ready=1 → q emits 0..99 in order with no gaps after fill; d_ready stays 1.
- Backpressure/full: q_ready=0, d_valid=1 continuously with d=1,2,3,... → exactly 4 beats accepted, then d_ready=0 and count=4. Release q_ready → q=1,2,3,4 in order.
- Random stall: random d_valid/q_ready at 50% for 10000 cycles → scoreboard matches; count equals the scoreboard depth every cycle.
- Flush: fill to 3 beats, assert flush with d_valid=1 → next cycle count=0, q_valid=0, flushed-cycle beat absent. Next beat after flush is the first output.
- Parity (PIPE_REG_PARITY_EN): force one stored data bit flipped in the stage-1 main register → parity_err=1 while that beat is on q; parity_err=0 for all other beats. Without the macro, parity_err is always 0.
